// File: rtl/text_line_renderer.sv
// text_line_renderer: walks a small string buffer through the 6x6 character
// generator ROM and emits one framebuffer pixel write per glyph pixel over a
// valid/ready port.
module text_line_renderer #(
    parameter int MAX_CHARS = 16,
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int PITCH     = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(MAX_CHARS)-1:0] wr_addr,
    input  logic [7:0]                   wr_data,
    input  logic                         start,
    input  logic [$clog2(MAX_CHARS):0]   len,
    input  logic [XW-1:0]                org_x,
    input  logic [YW-1:0]                org_y,
    input  logic                         transparent,
    output logic [7:0]                   rom_ch,
    output logic [2:0]                   rom_xoff,
    output logic [2:0]                   rom_yoff,
    input  logic                         rom_pixel,
    output logic                         px_valid,
    input  logic                         px_ready,
    output logic [XW-1:0]                px_x,
    output logic [YW-1:0]                px_y,
    output logic                         px_on,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = $clog2(MAX_CHARS);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [7:0]    r_buf [MAX_CHARS];
    logic [AW-1:0] r_ci;
    logic [2:0]    r_yo;
    logic [2:0]    r_xo;
    logic [LW-1:0] r_len;
    logic [XW-1:0] r_cbase;   // org_x + ci*PITCH, kept incrementally
    logic [YW-1:0] r_oy;
    logic          r_tr;

    logic          w_last;
    logic [AW-1:0] w_ci_nx;
    logic [2:0]    w_yo_nx;
    logic [2:0]    w_xo_nx;
    logic [XW-1:0] w_cbase_nx;

    assign rom_ch   = r_buf[r_ci];
    assign rom_xoff = r_xo;
    assign rom_yoff = r_yo;

    // String buffer: host writes only while no render is in progress
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Next position in xo -> yo -> ci order, and last-pixel detection
    always_comb begin
        w_xo_nx    = r_xo + 3'd1;
        w_yo_nx    = r_yo;
        w_ci_nx    = r_ci;
        w_cbase_nx = r_cbase;
        if (r_xo == 3'd5) begin
            w_xo_nx = '0;
            if (r_yo == 3'd5) begin
                w_yo_nx    = '0;
                w_ci_nx    = r_ci + AW'(1);
                w_cbase_nx = r_cbase + XW'(PITCH);
            end else begin
                w_yo_nx = r_yo + 3'd1;
            end
        end
        w_last = ({1'b0, r_ci} == (r_len - LW'(1))) && (r_yo == 3'd5) && (r_xo == 3'd5);
    end

    // Render sequencer with registered pixel-port and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ci     <= '0;
            r_yo     <= '0;
            r_xo     <= '0;
            r_len    <= '0;
            r_cbase  <= '0;
            r_oy     <= '0;
            r_tr     <= 1'b0;
            px_valid <= 1'b0;
            px_x     <= '0;
            px_y     <= '0;
            px_on    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_len   <= (len > LW'(MAX_CHARS)) ? LW'(MAX_CHARS) : len;
                        r_cbase <= org_x;
                        r_oy    <= org_y;
                        r_tr    <= transparent;
                        r_ci    <= '0;
                        r_yo    <= '0;
                        r_xo    <= '0;
                        if (len == '0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    px_x  <= r_cbase + XW'(r_xo);
                    px_y  <= r_oy + YW'(r_yo);
                    px_on <= rom_pixel;
                    if (r_tr && !rom_pixel) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_ci    <= '0;
                            r_yo    <= '0;
                            r_xo    <= '0;
                        end else begin
                            r_ci    <= w_ci_nx;
                            r_yo    <= w_yo_nx;
                            r_xo    <= w_xo_nx;
                            r_cbase <= w_cbase_nx;
                        end
                    end else begin
                        r_state  <= S_EMIT;
                        px_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (px_ready) begin
                        px_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_ci    <= '0;
                            r_yo    <= '0;
                            r_xo    <= '0;
                        end else begin
                            r_state <= S_SCAN;
                            r_ci    <= w_ci_nx;
                            r_yo    <= w_yo_nx;
                            r_xo    <= w_xo_nx;
                            r_cbase <= w_cbase_nx;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_line_renderer.sv
// Testbench for text_line_renderer: behavioural glyph ROM, scoreboard of
// expected pixel writes, directed render scenarios.
module tb_text_line_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [4:0] len;
    logic [9:0] org_x;
    logic [8:0] org_y;
    logic       transparent;
    logic [7:0] rom_ch;
    logic [2:0] rom_xoff;
    logic [2:0] rom_yoff;
    logic       rom_pixel;
    logic       px_valid;
    logic       px_ready;
    logic [9:0] px_x;
    logic [8:0] px_y;
    logic       px_on;
    logic       busy;
    logic       done;

    text_line_renderer #(.MAX_CHARS(16), .XW(10), .YW(9), .PITCH(7)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .org_x(org_x), .org_y(org_y), .transparent(transparent),
        .rom_ch(rom_ch), .rom_xoff(rom_xoff), .rom_yoff(rom_yoff), .rom_pixel(rom_pixel),
        .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y), .px_on(px_on),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Glyph rows, MSB = leftmost column
    function automatic logic [5:0] glyph_row(input logic [7:0] ch, input int unsigned y);
        logic [35:0] bits;
        case (ch)
            8'd65:   bits = 36'b011100_100010_100010_111110_100010_100010; // A
            8'd98:   bits = 36'b100000_100000_111100_100010_100010_111100; // b
            8'd33:   bits = 36'b001000_001000_001000_001000_000000_001000; // !
            8'd90:   bits = 36'b111110_000100_001000_010000_100000_111110; // Z
            default: bits = '0;
        endcase
        return bits[35 - 6*y -: 6];
    endfunction

    logic [5:0] w_row;
    assign w_row     = glyph_row(rom_ch, 32'(rom_yoff));
    assign rom_pixel = (rom_xoff <= 3'd5) ? w_row[3'd5 - rom_xoff] : 1'b0;

    typedef struct {
        int x;
        int y;
        int on;
        int ch;
    } px_t;

    px_t        sb[$];
    logic [7:0] tb_buf [16];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int start_cyc, hs_base, v_base, d_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel port monitor: compare every handshake against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (px_valid) valid_cnt++;
            if (px_valid && px_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_pixel", 32'd1, 32'd0);
                end else begin
                    px_t e;
                    e = sb.pop_front();
                    check("px_x", 32'(px_x), e.x);
                    check("px_y", 32'(px_y), e.y);
                    check("px_on", 32'(px_on), e.on);
                    check("rom_ch", 32'(rom_ch), e.ch);
                end
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic write_buf(input int a, input int d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
        tb_buf[a] = 8'(d);
    endtask

    task automatic launch(input int l, input int ox, input int oy, input int tr);
        int lc;
        lc = (l > 16) ? 16 : l;
        for (int ci = 0; ci < lc; ci++)
            for (int yo = 0; yo < 6; yo++)
                for (int xo = 0; xo < 6; xo++) begin
                    logic [5:0] r;
                    int on;
                    r = glyph_row(tb_buf[ci], yo);
                    on = int'(r[5 - xo]);
                    if (tr == 0 || on == 1)
                        sb.push_back('{x: (ox + ci*7 + xo) % 1024, y: (oy + yo) % 512,
                                       on: on, ch: int'(tb_buf[ci])});
                end
        hs_base = hs_cnt; v_base = valid_cnt; d_base = done_cnt;
        len = 5'(l); org_x = 10'(ox); org_y = 9'(oy); transparent = tr[0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic finish_render(input string tag, input int exp_delta, input int exp_hs);
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) break;
        end
        if (n == 3000) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        else           check({tag, "_done_cycle"}, 32'(cyc - start_cyc), 32'(exp_delta));
        check({tag, "_handshakes"}, 32'(hs_cnt - hs_base), 32'(exp_hs));
        check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt - d_base), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        len = '0; org_x = '0; org_y = '0; transparent = 1'b0; px_ready = 1'b1;
        for (int i = 0; i < 16; i++) tb_buf[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_px_valid", 32'(px_valid), 32'd0);
        check("rst_px_x", 32'(px_x), 32'd0);
        check("rst_px_y", 32'(px_y), 32'd0);
        check("rst_px_on", 32'(px_on), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_xoff", 32'(rom_xoff), 32'd0);
        check("rst_yoff", 32'(rom_yoff), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) write_buf(i, 32);

        // Single 'A' at (10,20)
        write_buf(0, 65);
        launch(1, 10, 20, 0);
        check("busy_after_start", 32'(busy), 32'd1);
        finish_render("single_A", 72, 36);

        // "Ab!" at origin, with ignored start/write while busy
        write_buf(0, 65); write_buf(1, 98); write_buf(2, 33);
        launch(3, 0, 0, 0);
        for (int n = 0; n < 200 && (hs_cnt - hs_base) < 5; n++) begin
            @(posedge clk); #1;
        end
        check("busy_mid_render", 32'(busy), 32'd1);
        start = 1'b1; len = 5'd1; org_x = 10'd100;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'd90;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        finish_render("string_Ab", 216, 108);

        // Backpressure at pixel 3; buffer[0] must still hold 'A'
        launch(1, 50, 60, 0);
        for (int n = 0; n < 50 && (hs_cnt - hs_base) < 3; n++) begin
            @(posedge clk); #1;
        end
        px_ready = 1'b0;
        begin
            int n;
            logic [9:0] bx; logic [8:0] by; logic bo; logic [2:0] bxo, byo;
            for (n = 0; n < 20; n++) begin
                @(negedge clk);
                if (px_valid) break;
            end
            check("bp_valid_seen", 32'(n < 20), 32'd1);
            bx = px_x; by = px_y; bo = px_on; bxo = rom_xoff; byo = rom_yoff;
            check("bp_pixel_index", 32'(rom_xoff), 32'd3);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check("bp_valid_held", 32'(px_valid), 32'd1);
                check("bp_x_stable", 32'(px_x), 32'(bx));
                check("bp_y_stable", 32'(px_y), 32'(by));
                check("bp_on_stable", 32'(px_on), 32'(bo));
                check("bp_xoff_frozen", 32'(rom_xoff), 32'(bxo));
                check("bp_yoff_frozen", 32'(rom_yoff), 32'(byo));
            end
        end
        px_ready = 1'b1;
        finish_render("backpressure", 77, 36);

        // Transparent blank glyph: no pixel writes, one cycle per skip
        @(posedge clk); #1;
        write_buf(0, 32);
        launch(1, 5, 5, 1);
        finish_render("transparent_space", 36, 0);
        check("transparent_no_valid", 32'(valid_cnt - v_base), 32'd0);

        // Zero length
        launch(0, 5, 5, 0);
        finish_render("len_zero", 0, 0);
        check("len_zero_no_valid", 32'(valid_cnt - v_base), 32'd0);

        // X wrap at the right edge
        @(posedge clk); #1;
        write_buf(0, 65);
        launch(1, 1020, 100, 0);
        finish_render("x_wrap", 72, 36);

        // Reset in the middle of a render, then a clean render
        launch(1, 200, 300, 0);
        for (int n = 0; n < 100 && (hs_cnt - hs_base) < 10; n++) begin
            @(posedge clk); #1;
        end
        #1;
        d_base = done_cnt;
        rst_n = 1'b0;
        #1;
        check("midrst_px_valid", 32'(px_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_xoff", 32'(rom_xoff), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done_cnt - d_base), 32'd0);
        launch(1, 30, 40, 0);
        finish_render("after_reset", 72, 36);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
